// File: rtl/usb_tx_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usb_pkg : state encoding and shared constants for usb_tx_arbiter |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package usb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    localparam logic [7:0] USB_ABORT_BYTE = 8'hFF;

    // Index width that stays at least one bit wide for a single source.
    function automatic int usb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_tx_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usb_tx_arbiter_if : source beats in, single host byte stream out |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface usb_tx_arbiter_if
    import usb_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int DWIDTH = 8
);
    localparam int SW = usb_idx_w(NSRC);

    logic [NSRC*DWIDTH-1:0] d;
    logic [NSRC-1:0]        dv;
    logic [NSRC-1:0]        dlast;
    logic [NSRC-1:0]        dready;
    logic [NSRC-1:0]        en;
    logic [DWIDTH-1:0]      q;
    logic                   qv;
    logic                   qlast;
    logic                   qready;
    logic [SW-1:0]          qsrc;
    logic                   abort;

    modport master (
        input  d, dv, dlast, en, qready,
        output dready, q, qv, qlast, qsrc, abort
    );

    modport slave (
        output d, dv, dlast, en, qready,
        input  dready, q, qv, qlast, qsrc, abort
    );

endinterface
`default_nettype wire

// File: rtl/usb_tx_arbiter_d1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | d1 : enable-gated D flop bank with async active-low clear        |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module d1 #(
    parameter int W = 1
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NSRC = 4,
    parameter int SW   = 2
) (
    input  logic [NSRC-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [NSRC-1:0] gnt,
    output logic [SW-1:0]   gnt_idx
);

    logic [NSRC-1:0] rot;
    logic [SW:0]     sum;
    logic            found;

    // Rotate so bit 0 is the pointer position, take the first set bit,
    // then map the offset back to an absolute source index.
    always_comb begin
        rot   = NSRC'({req, req} >> ptr);
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (SW+1)'(k);
            end
        end
        if (sum >= (SW+1)'(NSRC)) begin
            sum = sum - (SW+1)'(NSRC);
        end
        gnt_idx = sum[SW-1:0];
        gnt     = found ? (NSRC'(1) << gnt_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usb_tx_arbiter : packet-granular round-robin merge of NSRC reply |
// | sources onto one USB host byte stream, with idle-timeout abort   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module usb_tx_arbiter
    import usb_pkg::*;
#(
    parameter int                NSRC       = 4,
    parameter int                DWIDTH     = 8,
    parameter int                TIMEOUT    = 255,
    parameter logic [DWIDTH-1:0] ABORT_BYTE = DWIDTH'(USB_ABORT_BYTE)
) (
    input  logic             c,
    input  logic             rst_n,
    usb_tx_arbiter_if.master bus
);

    localparam int SW = usb_idx_w(NSRC);
    localparam int CW = usb_idx_w(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     owner_q, owner_d;
    logic [SW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              qv_q, qv_d;
    logic              abort_q, abort_d;

    logic [NSRC-1:0]   req;
    logic [NSRC-1:0]   gnt;
    logic [SW-1:0]     gnt_idx;
    logic [SW-1:0]     owner_next;
    logic [DWIDTH-1:0] src_byte [NSRC];
    logic              busy;
    logic              out_free;
    logic              own_dv;
    logic              own_last;
    logic              accept;
    logic              load;
    logic [DWIDTH-1:0] load_byte;
    logic              load_last;
    logic [DWIDTH:0]   q_reg;

    for (genvar i = 0; i < NSRC; i++) begin : g_unpack
        assign src_byte[i] = bus.d[i*DWIDTH +: DWIDTH];
    end

    assign req        = bus.dv & bus.en;
    assign busy       = (state_q == ST_BUSY);
    assign out_free   = !qv_q || bus.qready;
    assign own_dv     = bus.dv[owner_q];
    assign own_last   = bus.dlast[owner_q];
    assign accept     = busy && out_free && own_dv;
    assign owner_next = (owner_q == SW'(NSRC - 1)) ? '0 : owner_q + SW'(1);

    rr_arbiter #(
        .NSRC (NSRC),
        .SW   (SW)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        load      = 1'b0;
        load_byte = src_byte[owner_q];
        load_last = own_last;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt_idx;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    if (own_last) begin
                        state_d = ST_IDLE;
                        rr_d    = owner_next;
                    end
                end else if (!own_dv) begin
                    // Only a silent owner ages; host back-pressure never does.
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) begin
                        state_d = ST_ABORT;
                        abort_d = 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_byte = ABORT_BYTE;
                    load_last = 1'b1;
                    state_d   = ST_IDLE;
                    rr_d      = owner_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        qv_d = load | (qv_q & ~bus.qready);
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            qv_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            qv_q    <= qv_d;
            abort_q <= abort_d;
        end
    end

    d1 #(
        .W (DWIDTH + 1)
    ) u_out_reg (
        .c     (c),
        .rst_n (rst_n),
        .en    (load),
        .d     ({load_last, load_byte}),
        .q     (q_reg)
    );

    assign bus.dready = (busy && out_free) ? (NSRC'(1) << owner_q) : '0;
    assign bus.q      = q_reg[DWIDTH-1:0];
    assign bus.qlast  = q_reg[DWIDTH];
    assign bus.qv     = qv_q;
    assign bus.qsrc   = owner_q;
    assign bus.abort  = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_usb_tx_arbiter : directed scoreboard bench for usb_tx_arbiter |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_usb_tx_arbiter;

    localparam int NSRC    = 4;
    localparam int DWIDTH  = 8;
    localparam int TIMEOUT = 8;

    logic c = 1'b0;
    logic rst_n;

    always #5 c = ~c;

    usb_tx_arbiter_if #(.NSRC(NSRC), .DWIDTH(DWIDTH)) bus ();

    usb_tx_arbiter #(
        .NSRC       (NSRC),
        .DWIDTH     (DWIDTH),
        .TIMEOUT    (TIMEOUT),
        .ABORT_BYTE (8'hFF)
    ) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed { logic [7:0] b; logic last; } beat_t;
    typedef struct packed { logic [7:0] b; logic last; logic [1:0] src; } exp_t;

    beat_t srcq [NSRC][$];
    exp_t  expq [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic src_push(input int i, input logic [7:0] b, input logic last);
        beat_t x;
        x.b    = b;
        x.last = last;
        srcq[i].push_back(x);
    endtask

    task automatic exp_push(input logic [7:0] b, input logic last, input logic [1:0] src);
        exp_t e;
        e.b    = b;
        e.last = last;
        e.src  = src;
        expq.push_back(e);
    endtask

    task automatic drive_src_outputs();
        for (int i = 0; i < NSRC; i++) begin
            if (srcq[i].size() > 0) begin
                bus.dv[i]                   = 1'b1;
                bus.d[i*DWIDTH +: DWIDTH]   = srcq[i][0].b;
                bus.dlast[i]                = srcq[i][0].last;
            end else begin
                bus.dv[i]                   = 1'b0;
                bus.d[i*DWIDTH +: DWIDTH]   = '0;
                bus.dlast[i]                = 1'b0;
            end
        end
    endtask

    // Sources advance to their next beat after each accepted handshake.
    task automatic src_driver();
        logic [NSRC-1:0] fired;
        forever begin
            @(negedge c);
            fired = rst_n ? (bus.dv & bus.dready) : '0;
            @(posedge c);
            #1;
            for (int i = 0; i < NSRC; i++) begin
                if (fired[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            end
            drive_src_outputs();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge c);
            if (rst_n && bus.qv && bus.qready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got q=0x%0h qlast=%0b qsrc=%0d, required no beat",
                             bus.q, bus.qlast, bus.qsrc);
                end else begin
                    e = expq.pop_front();
                    if (bus.q !== e.b || bus.qlast !== e.last || bus.qsrc !== e.src) begin
                        errors++;
                        $display("FAIL beat: got q=0x%0h qlast=%0b qsrc=%0d, required q=0x%0h qlast=%0b qsrc=%0d",
                                 bus.q, bus.qlast, bus.qsrc, e.b, e.last, e.src);
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            @(negedge c);
            n++;
        end
        checks++;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL %s: got %0d beats outstanding after %0d cycles, required 0", name, expq.size(), n);
            expq.delete();
        end
        repeat (4) @(negedge c);
    endtask

    task automatic wait_qv(input string name, input int budget);
        int   n   = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge c);
            n++;
            hit = bus.qv;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: got qv=0 for %0d cycles, required qv=1", name, budget);
        end
    endtask

    task automatic wait_fire(input string name, input int i, input int budget);
        int   n   = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge c);
            n++;
            hit = bus.dv[i] & bus.dready[i];
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: got no handshake on source %0d in %0d cycles, required one", name, i, budget);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        bus.d      = '0;
        bus.dv     = '0;
        bus.dlast  = '0;
        bus.en     = '0;
        bus.qready = 1'b1;
        fork
            src_driver();
            monitor();
        join_none

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_qv",     32'(bus.qv),     0);
        chk("rst_q",      32'(bus.q),      0);
        chk("rst_qlast",  32'(bus.qlast),  0);
        chk("rst_qsrc",   32'(bus.qsrc),   0);
        chk("rst_abort",  32'(bus.abort),  0);
        chk("rst_dready", 32'(bus.dready), 0);
        repeat (2) @(posedge c);
        #2;
        rst_n  = 1'b1;
        bus.en = 4'b1111;

        // Two simultaneous 3-byte packets, pointer at 0.
        @(posedge c); #2;
        src_push(0, 8'h11, 1'b0); src_push(0, 8'h12, 1'b0); src_push(0, 8'h13, 1'b1);
        src_push(2, 8'h21, 1'b0); src_push(2, 8'h22, 1'b0); src_push(2, 8'h23, 1'b1);
        exp_push(8'h11, 1'b0, 2'd0); exp_push(8'h12, 1'b0, 2'd0); exp_push(8'h13, 1'b1, 2'd0);
        exp_push(8'h21, 1'b0, 2'd2); exp_push(8'h22, 1'b0, 2'd2); exp_push(8'h23, 1'b1, 2'd2);
        drive_src_outputs();
        wait_drain("s1_drain", 100);

        // Host stall mid-packet: 0x32 is held while qready is low.
        @(posedge c); #2;
        src_push(1, 8'h31, 1'b0); src_push(1, 8'h32, 1'b0);
        src_push(1, 8'h33, 1'b0); src_push(1, 8'h34, 1'b1);
        exp_push(8'h31, 1'b0, 2'd1); exp_push(8'h32, 1'b0, 2'd1);
        exp_push(8'h33, 1'b0, 2'd1); exp_push(8'h34, 1'b1, 2'd1);
        drive_src_outputs();
        wait_qv("s2_first_qv", 20);
        @(posedge c); #2;
        bus.qready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge c);
            chk("s2_hold_qv",     32'(bus.qv),     1);
            chk("s2_hold_q",      32'(bus.q),      32'h32);
            chk("s2_hold_qlast",  32'(bus.qlast),  0);
            chk("s2_hold_dready", 32'(bus.dready), 0);
            chk("s2_hold_abort",  32'(bus.abort),  0);
        end
        @(posedge c); #2;
        bus.qready = 1'b1;
        wait_drain("s2_drain", 100);

        // Owner goes silent after one byte: abort 8 cycles after that beat.
        @(posedge c); #2;
        src_push(2, 8'h41, 1'b0);
        exp_push(8'h41, 1'b0, 2'd2);
        exp_push(8'hFF, 1'b1, 2'd2);
        drive_src_outputs();
        wait_fire("s3_fire", 2, 20);
        for (int k = 1; k <= 10; k++) begin
            @(negedge c);
            chk("s3_abort", 32'(bus.abort), (k == 9) ? 32'd1 : 32'd0);
        end
        chk("s3_term_qv",    32'(bus.qv),    1);
        chk("s3_term_q",     32'(bus.q),     32'hFF);
        chk("s3_term_qlast", 32'(bus.qlast), 1);
        wait_drain("s3_drain", 100);

        // Pointer after the abort is 3, so order is 3, 0, 2.
        @(posedge c); #2;
        src_push(2, 8'h71, 1'b1); src_push(3, 8'h51, 1'b1); src_push(0, 8'h61, 1'b1);
        exp_push(8'h51, 1'b1, 2'd3); exp_push(8'h61, 1'b1, 2'd0); exp_push(8'h71, 1'b1, 2'd2);
        drive_src_outputs();
        wait_drain("s3b_drain", 100);

        // Reset mid-packet with a held byte; it must be discarded.
        @(posedge c); #2;
        bus.qready = 1'b0;
        src_push(1, 8'hC1, 1'b0); src_push(1, 8'hC2, 1'b0); src_push(1, 8'hC3, 1'b1);
        drive_src_outputs();
        wait_qv("s5_qv", 20);
        chk("s5_pre_abort", 32'(bus.abort), 0);
        @(posedge c); #3;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_qv",     32'(bus.qv),     0);
        chk("s5_rst_dready", 32'(bus.dready), 0);
        chk("s5_rst_abort",  32'(bus.abort),  0);
        chk("s5_rst_q",      32'(bus.q),      0);
        chk("s5_rst_qsrc",   32'(bus.qsrc),   0);
        for (int i = 0; i < NSRC; i++) srcq[i].delete();
        drive_src_outputs();
        repeat (2) @(posedge c);
        #2;
        rst_n      = 1'b1;
        bus.qready = 1'b1;
        bus.en     = 4'b1011;

        // Masked source 2; arbitration restarts at source 0.
        @(posedge c); #2;
        src_push(0, 8'h80, 1'b1); src_push(0, 8'h81, 1'b1);
        src_push(1, 8'h90, 1'b1); src_push(1, 8'h91, 1'b1);
        src_push(2, 8'hA0, 1'b1); src_push(2, 8'hA1, 1'b1);
        src_push(3, 8'hB0, 1'b1); src_push(3, 8'hB1, 1'b1);
        exp_push(8'h80, 1'b1, 2'd0); exp_push(8'h90, 1'b1, 2'd1); exp_push(8'hB0, 1'b1, 2'd3);
        exp_push(8'h81, 1'b1, 2'd0); exp_push(8'h91, 1'b1, 2'd1); exp_push(8'hB1, 1'b1, 2'd3);
        drive_src_outputs();
        wait_drain("s4_drain", 100);
        chk("s4_src2_pending", 32'(srcq[2].size()), 2);
        @(posedge c); #2;
        srcq[2].delete();
        drive_src_outputs();
        bus.en = 4'b1111;

        // Single-byte packet on source 3 with the host always ready.
        @(posedge c); #2;
        src_push(3, 8'hD3, 1'b1);
        exp_push(8'hD3, 1'b1, 2'd3);
        drive_src_outputs();
        wait_fire("s6_fire", 3, 20);
        @(negedge c);
        chk("s6_qv",     32'(bus.qv),     1);
        chk("s6_q",      32'(bus.q),      32'hD3);
        chk("s6_qlast",  32'(bus.qlast),  1);
        chk("s6_dready", 32'(bus.dready), 0);
        @(negedge c);
        chk("s6_qv_drop", 32'(bus.qv), 0);
        wait_drain("s6_drain", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
